// File: rtl/evm_pkg.sv
// Shared EVM definitions: voter FSM states, bus widths and the one-hot decoder
// that the ballot units also rely on.
package evm_pkg;

  localparam int unsigned CAND_W  = 4;
  localparam int unsigned TOTAL_W = 8;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StSelect,
    StCast,
    StLockout
  } state_e;

  // Highest set bit wins; callers only pass vectors already known to be one-hot.
  function automatic logic [CAND_W-1:0] onehot_to_idx(input logic [15:0] oh);
    logic [CAND_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (oh[i]) idx = CAND_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/input_sync_edge.sv
// Two-flop synchronizer for asynchronous button levels, plus a one-cycle
// rising-edge pulse per bit taken from the synchronized level.
module input_sync_edge #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             initializer_i,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] level_o,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] meta_q, sync_q, prev_q;

  always_ff @(posedge clk_i or posedge initializer_i) begin
    if (initializer_i) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/vote_controller.sv
// Voter front end: arm on officer enable, latch one candidate, cast on confirm,
// then lock out. Also keeps a saturating count of all casts.
module vote_controller
  import evm_pkg::*;
#(
  parameter int unsigned NUM_CANDIDATES = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      initializer_i,
  input  logic                      ballot_enable_i,
  input  logic [NUM_CANDIDATES-1:0] cand_buttons_i,
  input  logic                      confirm_i,
  output logic [CAND_W-1:0]         candidate_number_o,
  output logic                      vote_cast_o,
  output logic                      ready_o,
  output logic                      selected_o,
  output logic                      timeout_flag_o,
  output logic [TOTAL_W-1:0]        vote_total_o
);

  localparam int unsigned TimerW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned LockW  = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [LockW-1:0]  LockLast  = LockW'(LOCKOUT_CYCLES - 1);

  logic                      en_lvl, en_rise, cf_lvl, cf_rise;
  logic [NUM_CANDIDATES-1:0] cand_lvl, cand_rise;

  input_sync_edge #(.WIDTH(1)) u_sync_enable (
    .clk_i         (clk_i),
    .initializer_i (initializer_i),
    .async_i       (ballot_enable_i),
    .level_o       (en_lvl),
    .rise_o        (en_rise)
  );

  input_sync_edge #(.WIDTH(1)) u_sync_confirm (
    .clk_i         (clk_i),
    .initializer_i (initializer_i),
    .async_i       (confirm_i),
    .level_o       (cf_lvl),
    .rise_o        (cf_rise)
  );

  input_sync_edge #(.WIDTH(NUM_CANDIDATES)) u_sync_cand (
    .clk_i         (clk_i),
    .initializer_i (initializer_i),
    .async_i       (cand_buttons_i),
    .level_o       (cand_lvl),
    .rise_o        (cand_rise)
  );

  logic unused_lvl;
  assign unused_lvl = en_lvl ^ cf_lvl;

  // A press counts only if some bit rose and the whole synced vector is one-hot.
  logic              single_sel;
  logic [CAND_W-1:0] cand_idx;
  assign single_sel = (|cand_rise) && $onehot(cand_lvl);
  assign cand_idx   = onehot_to_idx(16'(cand_lvl));

  state_e             state_q, state_d;
  logic [TimerW-1:0]  timer_q, timer_d;
  logic [LockW-1:0]   lock_q, lock_d;
  logic [CAND_W-1:0]  cand_q, cand_d;
  logic [TOTAL_W-1:0] total_q, total_d;
  logic               flag_q, flag_d;

  always_ff @(posedge clk_i or posedge initializer_i) begin
    if (initializer_i) begin
      state_q <= StIdle;
      timer_q <= '0;
      lock_q  <= '0;
      cand_q  <= '0;
      total_q <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      lock_q  <= lock_d;
      cand_q  <= cand_d;
      total_q <= total_d;
      flag_q  <= flag_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = '0;
    lock_d  = '0;
    cand_d  = cand_q;
    total_d = total_q;
    flag_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en_rise) state_d = StArmed;
      end
      StArmed, StSelect: begin
        timer_d = timer_q + 1'b1;
        // Priority: confirm (SELECT only) > timeout > candidate re-latch.
        if ((state_q == StSelect) && cf_rise) begin
          state_d = StCast;
        end else if (timer_q == TimerLast) begin
          state_d = StIdle;
          flag_d  = 1'b1;
        end else if (single_sel) begin
          state_d = StSelect;
          cand_d  = cand_idx;
        end
      end
      StCast: begin
        state_d = StLockout;
        if (total_q != '1) total_d = total_q + 1'b1;
      end
      StLockout: begin
        lock_d = lock_q + 1'b1;
        if (lock_q == LockLast) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign candidate_number_o = cand_q;
  assign vote_cast_o        = (state_q == StCast);
  assign ready_o            = (state_q == StArmed) || (state_q == StSelect);
  assign selected_o         = (state_q == StSelect);
  assign timeout_flag_o     = flag_q;
  assign vote_total_o       = total_q;

endmodule

// File: tb/tb_vote_controller.sv
// Randomized self-checking bench for vote_controller against a session-level
// model of selections, casts and the saturating total.
module tb_vote_controller;

  localparam int unsigned NC = 8;

  logic          clk = 1'b0;
  logic          initializer, ballot_enable, confirm;
  logic [NC-1:0] cand_buttons;
  logic [3:0]    candidate_number;
  logic          vote_cast, ready, selected, timeout_flag;
  logic [7:0]    vote_total;

  int n_checks = 0;
  int n_errors = 0;
  int cast_seen = 0;
  int flag_seen = 0;
  int m_total, m_cand;

  vote_controller #(
    .NUM_CANDIDATES (NC),
    .TIMEOUT_CYCLES (1000),
    .LOCKOUT_CYCLES (16)
  ) dut (
    .clk_i              (clk),
    .initializer_i      (initializer),
    .ballot_enable_i    (ballot_enable),
    .cand_buttons_i     (cand_buttons),
    .confirm_i          (confirm),
    .candidate_number_o (candidate_number),
    .vote_cast_o        (vote_cast),
    .ready_o            (ready),
    .selected_o         (selected),
    .timeout_flag_o     (timeout_flag),
    .vote_total_o       (vote_total)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (vote_cast === 1'b1) cast_seen++;
    if (timeout_flag === 1'b1) flag_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int sat_inc(input int t);
    return (t < 255) ? t + 1 : 255;
  endfunction

  task automatic arm(output bit ok);
    ok = 1'b0;
    ballot_enable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (ready === 1'b1) begin ok = 1'b1; break; end
    end
    ballot_enable = 1'b0;
  endtask

  task automatic wait_cast(input int budget, output bit seen, output logic [3:0] c);
    seen = 1'b0;
    c = '0;
    for (int k = 0; k < budget; k++) begin
      tick(1);
      if (vote_cast === 1'b1) begin seen = 1'b1; c = candidate_number; break; end
    end
  endtask

  task automatic do_vote(input int idx, output bit seen, output logic [3:0] c);
    bit ok;
    arm(ok);
    cand_buttons = '0;
    cand_buttons[idx] = 1'b1;
    tick(3);
    cand_buttons = '0;
    tick(2);
    confirm = 1'b1;
    wait_cast(8, seen, c);
    confirm = 1'b0;
  endtask

  task automatic test_reset;
    initializer = 1'b1; ballot_enable = 1'b0; confirm = 1'b0; cand_buttons = '0;
    tick(3);
    n_checks++;
    if ({vote_cast, ready, selected, timeout_flag, candidate_number, vote_total} !== 16'h0) begin
      n_errors++; $display("FAIL reset_outputs: got cast=%b rdy=%b sel=%b to=%b cand=%0d tot=%0d want all 0",
        vote_cast, ready, selected, timeout_flag, candidate_number, vote_total);
    end
    initializer = 1'b0;
    tick(3);
    n_checks++;
    if ({vote_cast, ready, selected, timeout_flag, vote_total} !== 12'h0) begin
      n_errors++; $display("FAIL post_reset_idle: cast=%b rdy=%b sel=%b to=%b tot=%0d want all 0",
        vote_cast, ready, selected, timeout_flag, vote_total);
    end
    m_total = 0;
    m_cand = 0;
  endtask

  task automatic test_normal_vote;
    ballot_enable = 1'b1;
    tick(2);
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("FAIL arm_early: ready=%b want 0", ready); end
    tick(1);
    n_checks++;
    if (ready !== 1'b1) begin n_errors++; $display("FAIL arm_latency: ready=%b want 1", ready); end
    ballot_enable = 1'b0;
    cand_buttons = '0; cand_buttons[5] = 1'b1;
    tick(3);
    n_checks++;
    if (selected !== 1'b1 || candidate_number !== 4'd5) begin
      n_errors++; $display("FAIL select5: sel=%b cand=%0d want 1/5", selected, candidate_number);
    end
    cand_buttons = '0;
    tick(2);
    confirm = 1'b1;
    tick(2);
    n_checks++;
    if (vote_cast !== 1'b0) begin n_errors++; $display("FAIL cast_early: cast=%b want 0", vote_cast); end
    tick(1);
    n_checks++;
    if (vote_cast !== 1'b1 || candidate_number !== 4'd5 || vote_total !== 8'(m_total)) begin
      n_errors++; $display("FAIL cast_cycle: cast=%b cand=%0d tot=%0d want 1/5/%0d",
        vote_cast, candidate_number, vote_total, m_total);
    end
    tick(1);
    m_total = sat_inc(m_total);
    m_cand = 5;
    n_checks++;
    if (vote_cast !== 1'b0 || vote_total !== 8'(m_total) || ready !== 1'b0) begin
      n_errors++; $display("FAIL after_cast: cast=%b tot=%0d rdy=%b want 0/%0d/0",
        vote_cast, vote_total, ready, m_total);
    end
    confirm = 1'b0;
    tick(20);
  endtask

  task automatic test_change_of_mind;
    bit ok, seen;
    logic [3:0] c;
    int c0;
    arm(ok);
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL com_arm: ready=%b want 1", ready); end
    cand_buttons = '0; cand_buttons[2] = 1'b1; tick(3);
    cand_buttons = '0; tick(2);
    cand_buttons[7] = 1'b1; tick(3);
    n_checks++;
    if (candidate_number !== 4'd7) begin
      n_errors++; $display("FAIL com_relatch: cand=%0d want 7", candidate_number);
    end
    cand_buttons = '0; tick(2);
    #1 c0 = cast_seen;
    confirm = 1'b1;
    wait_cast(8, seen, c);
    confirm = 1'b0;
    m_total = sat_inc(m_total); m_cand = 7;
    tick(20);
    #1;
    n_checks++;
    if (!seen || c !== 4'd7 || cast_seen - c0 != 1 || vote_total !== 8'(m_total)) begin
      n_errors++; $display("FAIL com_cast: seen=%b cand=%0d casts=%0d tot=%0d want 1/7/1/%0d",
        seen, c, cast_seen - c0, vote_total, m_total);
    end
  endtask

  task automatic test_invalid;
    bit ok, seen;
    logic [3:0] c;
    int c0;
    arm(ok);
    cand_buttons = NC'(8'b0000_1010);
    tick(3);
    n_checks++;
    if (ready !== 1'b1 || selected !== 1'b0) begin
      n_errors++; $display("FAIL multi_press: rdy=%b sel=%b want 1/0", ready, selected);
    end
    cand_buttons = '0; tick(2);
    #1 c0 = cast_seen;
    confirm = 1'b1; tick(6); confirm = 1'b0; tick(2);
    #1;
    n_checks++;
    if (cast_seen != c0 || ready !== 1'b1 || selected !== 1'b0) begin
      n_errors++; $display("FAIL confirm_in_armed: casts=%0d rdy=%b sel=%b want 0/1/0",
        cast_seen - c0, ready, selected);
    end
    cand_buttons[4] = 1'b1; tick(3); cand_buttons = '0; tick(2);
    confirm = 1'b1;
    wait_cast(8, seen, c);
    confirm = 1'b0;
    m_total = sat_inc(m_total); m_cand = 4;
    tick(2);
    n_checks++;
    if (!seen || c !== 4'd4 || vote_total !== 8'(m_total)) begin
      n_errors++; $display("FAIL invalid_recover: seen=%b cand=%0d tot=%0d want 1/4/%0d",
        seen, c, vote_total, m_total);
    end
    tick(18);
  endtask

  task automatic test_random_sessions;
    bit ok, seen;
    logic [3:0] c;
    logic [NC-1:0] m;
    int a, b, r, np, idx;
    for (int s = 0; s < 12; s++) begin
      arm(ok);
      n_checks++;
      if (!ok || candidate_number !== 4'(m_cand)) begin
        n_errors++; $display("FAIL rnd_arm_hold s%0d: ok=%b cand=%0d want 1/%0d",
          s, ok, candidate_number, m_cand);
      end
      idx = -1;
      np = int'($urandom_range(1, 5));
      for (int p = 0; p <= np; p++) begin
        r = int'($urandom_range(0, 9));
        a = int'($urandom_range(0, NC - 1));
        b = (a + int'($urandom_range(1, NC - 1))) % NC;
        m = '0;
        if (p == np || r < 6) m[a] = 1'b1;
        else if (r < 8) begin m[a] = 1'b1; m[b] = 1'b1; end
        if ($countones(m) == 1) idx = a;
        cand_buttons = m;
        tick(3);
        n_checks++;
        if (selected !== (idx >= 0) || (idx >= 0 && candidate_number !== 4'(idx))) begin
          n_errors++; $display("FAIL rnd_press s%0d p%0d mask=%b: sel=%b cand=%0d want %0d",
            s, p, m, selected, candidate_number, idx);
        end
        cand_buttons = '0;
        tick(3);
      end
      confirm = 1'b1;
      wait_cast(8, seen, c);
      confirm = 1'b0;
      m_total = sat_inc(m_total); m_cand = idx;
      tick(1);
      n_checks++;
      if (!seen || c !== 4'(idx) || vote_total !== 8'(m_total)) begin
        n_errors++; $display("FAIL rnd_cast s%0d: seen=%b cand=%0d tot=%0d want 1/%0d/%0d",
          s, seen, c, vote_total, idx, m_total);
      end
      tick(19);
    end
  endtask

  task automatic test_lockout;
    bit seen;
    logic [3:0] c;
    int c0;
    do_vote(3, seen, c);
    m_total = sat_inc(m_total); m_cand = 3;
    #1 c0 = cast_seen;
    tick(2);
    ballot_enable = 1'b1; confirm = 1'b1;
    tick(3);
    ballot_enable = 1'b0; confirm = 1'b0;
    tick(9);
    ballot_enable = 1'b1;  // edge lands in the final lockout cycle
    tick(10);
    #1;
    n_checks++;
    if (!seen || ready !== 1'b0 || cast_seen != c0) begin
      n_errors++; $display("FAIL lockout_ignore: seen=%b rdy=%b extra_casts=%0d want 1/0/0",
        seen, ready, cast_seen - c0);
    end
    ballot_enable = 1'b0;
    tick(3);
    do_vote(1, seen, c);
    m_total = sat_inc(m_total); m_cand = 1;
    tick(15);
    ballot_enable = 1'b1;  // edge lands in the first idle cycle
    tick(2);
    n_checks++;
    if (ready !== 1'b0) begin n_errors++; $display("FAIL lockout_len_early: ready=%b want 0", ready); end
    tick(1);
    n_checks++;
    if (ready !== 1'b1) begin n_errors++; $display("FAIL lockout_len_rearm: ready=%b want 1", ready); end
    ballot_enable = 1'b0;
    cand_buttons[0] = 1'b1; tick(3); cand_buttons = '0; tick(2);
    confirm = 1'b1;
    wait_cast(8, seen, c);
    confirm = 1'b0;
    m_total = sat_inc(m_total); m_cand = 0;
    tick(2);
    n_checks++;
    if (!seen || c !== 4'd0 || vote_total !== 8'(m_total)) begin
      n_errors++; $display("FAIL rearm_vote: seen=%b cand=%0d tot=%0d want 1/0/%0d",
        seen, c, vote_total, m_total);
    end
    tick(18);
  endtask

  task automatic test_timeout;
    bit ok;
    logic prev_ready;
    int got;
    arm(ok);
    got = 0;
    prev_ready = ready;
    for (int k = 1; k <= 1100; k++) begin
      prev_ready = ready;
      tick(1);
      if (timeout_flag === 1'b1) begin got = k; break; end
    end
    n_checks++;
    if (!ok || got != 1000 || ready !== 1'b0 || prev_ready !== 1'b1) begin
      n_errors++; $display("FAIL timeout_time: ok=%b flag_at=%0d rdy=%b prev_rdy=%b want 1/1000/0/1",
        ok, got, ready, prev_ready);
    end
    tick(1);
    n_checks++;
    if (timeout_flag !== 1'b0 || vote_total !== 8'(m_total)) begin
      n_errors++; $display("FAIL timeout_pulse: flag=%b tot=%0d want 0/%0d",
        timeout_flag, vote_total, m_total);
    end
    tick(3);
  endtask

  task automatic test_timeout_races;
    bit ok;
    int f0;
    arm(ok);
    #1 f0 = flag_seen;
    cand_buttons[6] = 1'b1; tick(3); cand_buttons = '0;
    tick(497);
    cand_buttons[2] = 1'b1; tick(3); cand_buttons = '0;
    n_checks++;
    if (selected !== 1'b1 || candidate_number !== 4'd2) begin
      n_errors++; $display("FAIL race_reselect: sel=%b cand=%0d want 1/2", selected, candidate_number);
    end
    tick(494);
    confirm = 1'b1;  // edge coincides with the last session cycle
    tick(3);
    n_checks++;
    if (!ok || vote_cast !== 1'b1 || timeout_flag !== 1'b0 || candidate_number !== 4'd2) begin
      n_errors++; $display("FAIL confirm_vs_timeout: cast=%b flag=%b cand=%0d want 1/0/2",
        vote_cast, timeout_flag, candidate_number);
    end
    confirm = 1'b0;
    m_total = sat_inc(m_total); m_cand = 2;
    tick(20);
    #1;
    n_checks++;
    if (flag_seen != f0 || vote_total !== 8'(m_total)) begin
      n_errors++; $display("FAIL race_no_flag: flags=%0d tot=%0d want 0/%0d",
        flag_seen - f0, vote_total, m_total);
    end
    arm(ok);
    tick(997);
    cand_buttons[5] = 1'b1;  // edge coincides with the last session cycle
    tick(3);
    n_checks++;
    if (timeout_flag !== 1'b1 || selected !== 1'b0 || ready !== 1'b0) begin
      n_errors++; $display("FAIL cand_vs_timeout: flag=%b sel=%b rdy=%b want 1/0/0",
        timeout_flag, selected, ready);
    end
    cand_buttons = '0;
    tick(2);
    n_checks++;
    if (candidate_number !== 4'(m_cand)) begin
      n_errors++; $display("FAIL cand_vs_timeout_hold: cand=%0d want %0d", candidate_number, m_cand);
    end
  endtask

  task automatic test_reset_mid_cast;
    bit seen;
    logic [3:0] c;
    int c0;
    do_vote(6, seen, c);
    #2 initializer = 1'b1;
    #1;
    n_checks++;
    if (!seen || {vote_cast, ready, selected, timeout_flag, candidate_number, vote_total} !== 16'h0) begin
      n_errors++; $display("FAIL reset_mid_cast: seen=%b cast=%b rdy=%b cand=%0d tot=%0d want 1/0/0/0/0",
        seen, vote_cast, ready, candidate_number, vote_total);
    end
    c0 = cast_seen;
    @(negedge clk) initializer = 1'b0;
    m_total = 0; m_cand = 0;
    tick(25);
    #1;
    n_checks++;
    if (cast_seen != c0 || vote_total !== 8'd0 || ready !== 1'b0) begin
      n_errors++; $display("FAIL reset_discard: casts=%0d tot=%0d rdy=%b want 0/0/0",
        cast_seen - c0, vote_total, ready);
    end
  endtask

  task automatic test_saturation;
    bit seen;
    logic [3:0] c;
    int c0, miss;
    #1 c0 = cast_seen;
    miss = 0;
    for (int i = 0; i < 256; i++) begin
      do_vote(int'($urandom_range(0, NC - 1)), seen, c);
      if (!seen) miss++;
      m_total = sat_inc(m_total);
      tick(20);
      if (i == 254) begin
        n_checks++;
        if (vote_total !== 8'(m_total)) begin
          n_errors++; $display("FAIL sat_reach: tot=%0d want %0d", vote_total, m_total);
        end
      end
    end
    #1;
    n_checks++;
    if (vote_total !== 8'(m_total) || cast_seen - c0 != 256 || miss != 0) begin
      n_errors++; $display("FAIL sat_hold: tot=%0d casts=%0d missed=%0d want %0d/256/0",
        vote_total, cast_seen - c0, miss, m_total);
    end
  endtask

  initial begin
    test_reset;
    test_normal_vote;
    test_change_of_mind;
    test_invalid;
    test_random_sessions;
    test_lockout;
    test_timeout;
    test_timeout_races;
    test_reset_mid_cast;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1, "watchdog expired");
  end

endmodule
